// File: rtl/bram_scan_pkg.sv
// Shared types and default sizing for the BRAM scan sequencer.
package bram_scan_pkg;

  // Scan phases, in the order a scan walks through them.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    SETTLE,
    CAPTURE,
    UNLOAD,
    DONE
  } state_e;

  localparam int DEF_DIN_N      = 8;
  localparam int DEF_DOUT_N     = 100;
  localparam int DEF_SETTLE_CYC = 4;

endpackage

// File: rtl/bram_scan_sipo.sv
// Serial-in/parallel-out capture register for the scan result.
// The parallel output only changes on load_en, so a half-shifted word is never visible.
module bram_scan_sipo
  import bram_scan_pkg::*;
#(
  parameter int N = DEF_DOUT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         load_en,
  input  logic         sdi,
  output logic [N-1:0] pout
);

  logic [N-1:0] shift_q, shift_d;
  logic [N-1:0] pout_q, pout_d;
  logic [N-1:0] shifted;

  // Shift toward the MSB, new bit enters at the LSB. load_en arrives in the
  // last shift cycle, so the output takes the shifted value including that bit.
  always_comb begin
    shifted = (shift_q << 1) | N'(sdi);
    shift_d = shift_q;
    pout_d  = pout_q;
    if (shift_en) shift_d = shifted;
    if (load_en)  pout_d  = shifted;
  end

  // Shift and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      pout_q  <= '0;
    end else begin
      shift_q <= shift_d;
      pout_q  <= pout_d;
    end
  end

  assign pout = pout_q;

endmodule

// File: rtl/bram_scan_ctrl.sv
// Sequencer for the serial di/stb/do port of the BRAM timing-grid fuzzer top:
// shift stimulus out, strobe apply, settle, strobe capture, shift result back in.
module bram_scan_ctrl
  import bram_scan_pkg::*;
#(
  parameter int DIN_N      = DEF_DIN_N,
  parameter int DOUT_N     = DEF_DOUT_N,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int CNT_W      = $clog2((((DIN_N > DOUT_N) ? DIN_N : DOUT_N) > SETTLE_CYC
                                     ? ((DIN_N > DOUT_N) ? DIN_N : DOUT_N)
                                     : SETTLE_CYC) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIN_N-1:0]  din_word,
  output logic              busy,
  output logic              done,
  output logic [DOUT_N-1:0] dout_word,
  output logic              scan_di,
  output logic              scan_stb,
  input  logic              scan_do
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIN_N-1:0]   piso_q, piso_d;
  logic               cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next-state logic; the phase counter is reloaded with (length-1) on every
  // phase entry and only decremented while nonzero, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    piso_d  = piso_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(DIN_N - 1);
          piso_d  = din_word;
        end
      end
      LOAD: begin
        piso_d = piso_q << 1;
        if (cnt_zero) begin
          state_d = APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      APPLY: begin
        state_d = SETTLE;
        cnt_d   = CNT_W'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        state_d = UNLOAD;
        cnt_d   = CNT_W'(DOUT_N - 1);
      end
      UNLOAD: begin
        if (cnt_zero) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and stimulus shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      piso_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      piso_q  <= piso_d;
    end
  end

  // Outputs decode only flops, so nothing combinational reaches them from inputs.
  assign busy     = (state_q == LOAD) || (state_q == APPLY) || (state_q == SETTLE) ||
                    (state_q == CAPTURE) || (state_q == UNLOAD);
  assign done     = (state_q == DONE);
  assign scan_stb = (state_q == APPLY) || (state_q == CAPTURE);
  assign scan_di  = (state_q == LOAD) && piso_q[DIN_N-1];

  bram_scan_sipo #(.N(DOUT_N)) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (state_q == UNLOAD),
    .load_en  ((state_q == UNLOAD) && cnt_zero),
    .sdi      (scan_do),
    .pout     (dout_word)
  );

endmodule

// File: tb/tb_bram_scan_ctrl.sv
module tb_bram_scan_ctrl;

  localparam int DN = 8, ON = 100, ST = 4;
  localparam int SDN = 2, SON = 3, SST = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        scan_do = 1'b0;
  logic [7:0]  din_word = '0;

  logic        d_busy, d_done, d_stb, d_di;
  logic [99:0] d_dout;
  logic        s_busy, s_done, s_stb, s_di;
  logic [2:0]  s_dout;

  bit          sel = 1'b0;
  logic        obs_busy, obs_done, obs_stb, obs_di;
  logic [99:0] obs_dout;

  int n_chk = 0;
  int n_pass = 0;

  int cur_dn = DN, cur_on = ON, cur_st = ST;
  logic [99:0] cur_res = '0;
  logic [99:0] prev_dout = '0;

  int stb_cnt = 0;
  int uidx = -1;

  always #5 clk = ~clk;

  bram_scan_ctrl #(.DIN_N(DN), .DOUT_N(ON), .SETTLE_CYC(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .din_word(din_word),
    .busy(d_busy), .done(d_done), .dout_word(d_dout),
    .scan_di(d_di), .scan_stb(d_stb), .scan_do(scan_do)
  );

  bram_scan_ctrl #(.DIN_N(SDN), .DOUT_N(SON), .SETTLE_CYC(SST)) dut_small (
    .clk(clk), .rst(rst), .start(start), .din_word(din_word[1:0]),
    .busy(s_busy), .done(s_done), .dout_word(s_dout),
    .scan_di(s_di), .scan_stb(s_stb), .scan_do(scan_do)
  );

  assign obs_busy = sel ? s_busy : d_busy;
  assign obs_done = sel ? s_done : d_done;
  assign obs_stb  = sel ? s_stb  : d_stb;
  assign obs_di   = sel ? s_di   : d_di;
  assign obs_dout = sel ? {97'b0, s_dout} : d_dout;

  // Behavioural ROI top: every second strobe snapshots cur_res, which is then
  // served MSB first, one bit per cycle, starting in the cycle after the strobe.
  always @(negedge clk) begin
    if (rst) begin
      stb_cnt = 0;
      uidx    = -1;
      scan_do = 1'b0;
    end else begin
      if (uidx >= 0 && uidx < cur_on) begin
        scan_do = cur_res[cur_on-1-uidx];
        uidx++;
      end else begin
        scan_do = 1'($urandom);
        uidx    = -1;
      end
      if (obs_stb) begin
        stb_cnt++;
        if (stb_cnt % 2 == 0) uidx = 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected {busy, done, stb, di} for cycle c after acceptance (c >= 1).
  function automatic logic [3:0] exp_out(int c, logic [7:0] din);
    int td;
    logic b, d, s, i;
    td = cur_dn + cur_on + cur_st + 3;
    b = (c >= 1) && (c < td);
    d = (c == td);
    s = (c == cur_dn + 1) || (c == cur_dn + 2 + cur_st);
    i = (c >= 1 && c <= cur_dn) ? din[cur_dn-c] : 1'b0;
    return {b, d, s, i};
  endfunction

  task automatic check_cycle(input string tag, input int c, input logic [7:0] din);
    logic [3:0] e;
    e = exp_out(c, din);
    check_val($sformatf("%s.busy@%0d", tag, c), obs_busy, e[3]);
    check_val($sformatf("%s.done@%0d", tag, c), obs_done, e[2]);
    check_val($sformatf("%s.stb@%0d", tag, c),  obs_stb,  e[1]);
    check_val($sformatf("%s.di@%0d", tag, c),   obs_di,   e[0]);
  endtask

  task automatic run_scan(input string tag, input logic [7:0] din, input logic [99:0] res, input bit noise);
    int td;
    td = cur_dn + cur_on + cur_st + 3;
    @(negedge clk);
    din_word = din;
    start    = 1'b1;
    cur_res  = res;
    for (int c = 1; c <= td + 1; c++) begin
      @(negedge clk);
      check_cycle(tag, c, din);
      if (c == td - 1) check_val($sformatf("%s.dout_hold", tag), obs_dout, prev_dout);
      if (c >= td)     check_val($sformatf("%s.dout@%0d", tag, c), obs_dout, res);
      if (c == 1) start = 1'b0;
      if (noise) begin
        if (c == 2) din_word = ~din;
        if (c == 3 || c == cur_dn + 2) start = 1'b1;
        if (c == 4 || c == cur_dn + 3) start = 1'b0;
      end
    end
    prev_dout = res;
  endtask

  function automatic logic [99:0] rand_res();
    logic [99:0] r;
    for (int i = 0; i < 100; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  initial begin
    logic [99:0] alt;
    logic [99:0] r;
    logic [7:0]  dw;
    int dc[$];
    int bad;
    int ndone;

    // Reset state
    #3;
    check_val("rst.busy", d_busy, 1'b0);
    check_val("rst.done", d_done, 1'b0);
    check_val("rst.stb",  d_stb,  1'b0);
    check_val("rst.di",   d_di,   1'b0);
    check_val("rst.dout", d_dout, 100'h0);
    check_val("rst.sdout", s_dout, 3'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed scans
    run_scan("a5", 8'hA5, 100'h1, 1'b0);
    for (int i = 0; i < 100; i++) alt[i] = 1'(i % 2);
    run_scan("alt", 8'h3C, alt, 1'b0);
    check_val("alt.bit99", obs_dout[99], 1'b1);
    check_val("alt.bit98", obs_dout[98], 1'b0);
    check_val("alt.bit0",  obs_dout[0],  1'b0);

    // Randomised scans, with stray start pulses and din_word changes mid-scan
    for (int k = 0; k < 4; k++) begin
      dw = 8'($urandom);
      r  = rand_res();
      run_scan($sformatf("rnd%0d", k), dw, r, 1'(k % 2));
    end

    // start held high: back-to-back scans with no queueing
    r = rand_res();
    @(negedge clk);
    din_word = 8'($urandom);
    cur_res  = r;
    start    = 1'b1;
    bad      = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (obs_done) dc.push_back(c);
      if (obs_done && obs_busy) bad++;
      if (c == 116) check_val("hold.busy116", obs_busy, 1'b0);
      if (c == 117) check_val("hold.busy117", obs_busy, 1'b1);
    end
    start = 1'b0;
    ndone = dc.size();
    check_val("hold.ndone", ndone, 2);
    check_val("hold.done1", (ndone > 0) ? dc[0] : -1, 115);
    check_val("hold.done2", (ndone > 1) ? dc[1] : -1, 231);
    check_val("hold.busy_in_done", bad, 0);
    check_val("hold.dout", obs_dout, r);
    repeat (130) @(negedge clk);
    prev_dout = r;

    // Asynchronous reset in UNLOAD cycle 50
    @(negedge clk);
    din_word = 8'($urandom);
    cur_res  = rand_res();
    start    = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check_val("abort.busy_before", obs_busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_val("abort.busy", d_busy, 1'b0);
    check_val("abort.done", d_done, 1'b0);
    check_val("abort.stb",  d_stb,  1'b0);
    check_val("abort.di",   d_di,   1'b0);
    check_val("abort.dout", d_dout, 100'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (obs_done) ndone++;
    end
    check_val("abort.no_done", ndone, 0);
    prev_dout = '0;
    run_scan("post_abort", 8'($urandom), rand_res(), 1'b0);

    // Minimum-size instance
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    sel    = 1'b1;
    cur_dn = SDN;
    cur_on = SON;
    cur_st = SST;
    prev_dout = '0;
    @(negedge clk);
    run_scan("small_a", 8'h02, 100'h5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      r = rand_res() & 100'h7;
      run_scan($sformatf("small_r%0d", k), 8'($urandom), r, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
